// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory bus between instruction fetch
// and data access. Only one transaction is in flight at a time. MEM normally wins,
// but IF is forced through after STARVE_MAX consecutive MEM grants while it waits.
// A fetch killed by a branch flush still completes on the bus, and its response
// is swallowed.
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  // fetch port
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                stall_if,
  input  logic                flush_if,
  // data port
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  output logic                mem_done,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_mem,
  // bus
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_wstrb,
  input  logic                bus_gnt,
  input  logic                bus_rvalid,
  input  logic [DATA_W-1:0]   bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_RESP} state_t;
  typedef enum logic {OWN_IF, OWN_MEM} owner_t;

  localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);

  state_t           state, state_next;
  owner_t           owner;
  logic             drop, drop_next;
  logic [CNT_W-1:0] starve_cnt, starve_next;
  logic             grant_mem, grant_if;
  logic             resp_fire;

  // Next-state, arbitration decision, drop flag and starvation counter update.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_next  = state;
    drop_next   = drop;
    starve_next = starve_cnt;
    grant_mem   = 1'b0;
    grant_if    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (mem_req && (starve_cnt < STARVE_LIM || !if_req)) begin
          grant_mem  = 1'b1;
          state_next = S_CMD;
          if (if_req && starve_cnt < STARVE_LIM) starve_next = starve_cnt + 1'b1;
        end else if (if_req && !flush_if) begin
          grant_if    = 1'b1;
          state_next  = S_CMD;
          starve_next = '0;
        end
      end
      S_CMD: begin
        if (bus_gnt) state_next = S_RESP;
        if (flush_if && owner == OWN_IF) drop_next = 1'b1;
      end
      S_RESP: begin
        if (bus_rvalid) begin
          state_next = S_IDLE;
          drop_next  = 1'b0;
        end else if (flush_if && owner == OWN_IF) begin
          drop_next = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State, ownership and registered command fields; command is latched on grant
  // and held untouched through CMD and RESP.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every flop samples the
    // pre-edge values regardless of statement order.
    if (rst) begin
      state      <= S_IDLE;
      owner      <= OWN_IF;
      drop       <= 1'b0;
      starve_cnt <= '0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_wstrb  <= '0;
    end else begin
      state      <= state_next;
      drop       <= drop_next;
      starve_cnt <= starve_next;
      if (grant_mem) begin
        owner     <= OWN_MEM;
        bus_we    <= mem_we;
        bus_addr  <= mem_addr;
        bus_wdata <= mem_wdata;
        bus_wstrb <= mem_wstrb;
      end else if (grant_if) begin
        owner     <= OWN_IF;
        bus_we    <= 1'b0;
        bus_addr  <= if_addr;
        bus_wdata <= '0;
        bus_wstrb <= '0;
      end
    end
  end

  // Response routing and stall requests; a flush landing with the response kills it.
  assign bus_req   = (state == S_CMD);
  assign resp_fire = (state == S_RESP) && bus_rvalid;
  assign mem_done  = resp_fire && (owner == OWN_MEM);
  assign if_rvalid = resp_fire && (owner == OWN_IF) && !drop && !flush_if;
  assign mem_rdata = mem_done  ? bus_rdata : '0;
  assign if_rdata  = if_rvalid ? bus_rdata : '0;
  assign stall_if  = if_req  && !if_rvalid;
  assign stall_mem = mem_req && !mem_done;

  // A response is only legal while one is outstanding.
  rvalid_in_resp: assert property (@(posedge clk) disable iff (rst)
    bus_rvalid |-> state == S_RESP)
    else $error("bus_rvalid outside RESP");

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed cycle-by-cycle checks of mem_port_arbiter.
// Inputs change 1 ns after the rising edge; outputs are compared 1 ns later.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, flush_if, if_rvalid, stall_if;
  logic [63:0] if_addr, if_rdata;
  logic        mem_req, mem_we, mem_done, stall_mem;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wstrb;
  logic        bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [63:0] bus_addr, bus_wdata, bus_rdata;
  logic [7:0]  bus_wstrb;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .stall_if(stall_if), .flush_if(flush_if),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_done(mem_done), .mem_rdata(mem_rdata), .stall_mem(stall_mem),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Entered at the start of a CMD cycle: holds gnt low for 'waits' cycles, checking
  // the command is presented and stable, then grants and returns in the RESP cycle
  // with bus_rvalid driven high (caller checks the response and clears it).
  task automatic serve(input logic [63:0] exp_addr, input logic exp_we,
                       input logic [7:0] exp_strb, input logic [63:0] exp_wdata,
                       input int waits, input logic [63:0] rdata);
    for (int w = 0; w <= waits; w++) begin
      bus_gnt = (w == waits);
      settle();
      check("bus_req", {63'b0, bus_req}, 64'd1);
      check("bus_addr", bus_addr, exp_addr);
      check("bus_we", {63'b0, bus_we}, {63'b0, exp_we});
      check("bus_wstrb", {56'b0, bus_wstrb}, {56'b0, exp_strb});
      check("bus_wdata", bus_wdata, exp_wdata);
      check("stall_mem_cmd", {63'b0, stall_mem}, {63'b0, mem_req});
      cyc();
    end
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = rdata;
    settle();
  endtask

  initial begin
    rst = 1'b1; if_req = 0; flush_if = 0; if_addr = '0;
    mem_req = 0; mem_we = 0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = '0;

    // Reset: outputs quiet, stall follows the comb equation even in reset.
    cyc(); cyc();
    mem_req = 1'b1;
    settle();
    check("rst_stall_mem", {63'b0, stall_mem}, 64'd1);
    check("rst_bus_req", {63'b0, bus_req}, 64'd0);
    check("rst_bus_addr", bus_addr, 64'd0);
    check("rst_bus_wdata", bus_wdata, 64'd0);
    check("rst_bus_wstrb", {56'b0, bus_wstrb}, 64'd0);
    check("rst_bus_we", {63'b0, bus_we}, 64'd0);
    check("rst_if_rvalid", {63'b0, if_rvalid}, 64'd0);
    check("rst_mem_done", {63'b0, mem_done}, 64'd0);
    check("rst_if_rdata", if_rdata, 64'd0);
    check("rst_mem_rdata", mem_rdata, 64'd0);
    check("rst_stall_if", {63'b0, stall_if}, 64'd0);
    mem_req = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();

    // 1: solo fetch, gnt and rvalid at the earliest cycles.
    if_req = 1; if_addr = 64'h1000;
    settle();
    check("t1_stall_if_idle", {63'b0, stall_if}, 64'd1);
    check("t1_bus_req_idle", {63'b0, bus_req}, 64'd0);
    cyc();
    serve(64'h1000, 1'b0, 8'h00, 64'h0, 0, 64'hDEAD);
    check("t1_if_rvalid", {63'b0, if_rvalid}, 64'd1);
    check("t1_if_rdata", if_rdata, 64'hDEAD);
    check("t1_stall_if", {63'b0, stall_if}, 64'd0);
    check("t1_mem_done", {63'b0, mem_done}, 64'd0);
    cyc();
    bus_rvalid = 0; if_req = 0;
    settle();
    check("t1_if_rvalid_end", {63'b0, if_rvalid}, 64'd0);
    check("t1_bus_req_end", {63'b0, bus_req}, 64'd0);

    // 2: collision, MEM load served first, IF after one idle cycle.
    if_req = 1; if_addr = 64'h3000;
    mem_req = 1; mem_we = 0; mem_addr = 64'h2000; mem_wdata = '0; mem_wstrb = '0;
    settle();
    check("t2_stall_mem", {63'b0, stall_mem}, 64'd1);
    check("t2_stall_if", {63'b0, stall_if}, 64'd1);
    cyc();
    serve(64'h2000, 1'b0, 8'h00, 64'h0, 0, 64'h1111);
    check("t2_mem_done", {63'b0, mem_done}, 64'd1);
    check("t2_mem_rdata", mem_rdata, 64'h1111);
    check("t2_if_rvalid_n", {63'b0, if_rvalid}, 64'd0);
    check("t2_stall_mem_done", {63'b0, stall_mem}, 64'd0);
    check("t2_stall_if_wait", {63'b0, stall_if}, 64'd1);
    cyc();
    bus_rvalid = 0; mem_req = 0;
    settle();
    check("t2_gap_bus_req", {63'b0, bus_req}, 64'd0);
    cyc();
    serve(64'h3000, 1'b0, 8'h00, 64'h0, 0, 64'h3333);
    check("t2_if_rvalid", {63'b0, if_rvalid}, 64'd1);
    check("t2_if_rdata", if_rdata, 64'h3333);
    cyc();
    bus_rvalid = 0; if_req = 0;

    // 3: starvation, four MEM grants then IF, then MEM wins again (counter cleared).
    if_req = 1; if_addr = 64'h4000; mem_req = 1; mem_we = 0;
    for (int k = 0; k < 6; k++) begin
      mem_addr = 64'h5000 + 64'(k);
      settle();
      check("t3_idle_bus_req", {63'b0, bus_req}, 64'd0);
      cyc();
      if (k == 4) serve(64'h4000, 1'b0, 8'h00, 64'h0, 0, 64'(k));
      else        serve(64'h5000 + 64'(k), 1'b0, 8'h00, 64'h0, 0, 64'(k));
      check("t3_mem_done", {63'b0, mem_done}, (k != 4) ? 64'd1 : 64'd0);
      check("t3_if_rvalid", {63'b0, if_rvalid}, (k == 4) ? 64'd1 : 64'd0);
      cyc();
      bus_rvalid = 0;
      if (k == 4) if_addr = 64'h4008;
    end
    if_req = 0; mem_req = 0;
    cyc();

    // 4a: flush while in RESP; orphan response swallowed, new PC issued afterwards.
    if_req = 1; if_addr = 64'h6000;
    cyc();
    bus_gnt = 1;
    settle();
    check("t4_bus_addr_old", bus_addr, 64'h6000);
    cyc();
    bus_gnt = 0; flush_if = 1; if_addr = 64'h7000;
    settle();
    check("t4_if_rvalid_flush", {63'b0, if_rvalid}, 64'd0);
    check("t4_stall_if_flush", {63'b0, stall_if}, 64'd1);
    cyc();
    flush_if = 0; bus_rvalid = 1; bus_rdata = 64'hBAD;
    settle();
    check("t4_if_rvalid_drop", {63'b0, if_rvalid}, 64'd0);
    check("t4_if_rdata_drop", if_rdata, 64'd0);
    check("t4_stall_if_drop", {63'b0, stall_if}, 64'd1);
    cyc();
    bus_rvalid = 0;
    settle();
    check("t4_idle_bus_req", {63'b0, bus_req}, 64'd0);
    cyc();
    serve(64'h7000, 1'b0, 8'h00, 64'h0, 0, 64'h7777);
    check("t4_new_if_rvalid", {63'b0, if_rvalid}, 64'd1);
    check("t4_new_if_rdata", if_rdata, 64'h7777);
    cyc();
    bus_rvalid = 0;

    // 4b: flush on the rvalid cycle drops it; flush in IDLE blocks the request.
    if_addr = 64'hA000;
    cyc();
    serve(64'hA000, 1'b0, 8'h00, 64'h0, 0, 64'hAAAA);
    flush_if = 1;
    settle();
    check("t4b_if_rvalid_same", {63'b0, if_rvalid}, 64'd0);
    cyc();
    bus_rvalid = 0; if_addr = 64'hB000;
    cyc();
    flush_if = 0;
    settle();
    check("t4b_idle_flush_blk", {63'b0, bus_req}, 64'd0);
    cyc();
    serve(64'hB000, 1'b0, 8'h00, 64'h0, 0, 64'hBBBB);
    check("t4b_if_rvalid", {63'b0, if_rvalid}, 64'd1);
    check("t4b_if_rdata", if_rdata, 64'hBBBB);
    cyc();
    bus_rvalid = 0; if_req = 0;

    // 5: store with three wait states before gnt.
    mem_req = 1; mem_we = 1; mem_addr = 64'h8000;
    mem_wdata = 64'h0123_4567_89AB_CDEF; mem_wstrb = 8'h0F;
    cyc();
    serve(64'h8000, 1'b1, 8'h0F, 64'h0123_4567_89AB_CDEF, 3, 64'h0);
    check("t5_mem_done", {63'b0, mem_done}, 64'd1);
    check("t5_stall_mem", {63'b0, stall_mem}, 64'd0);
    cyc();
    bus_rvalid = 0; mem_req = 0; mem_we = 0;
    settle();
    check("t5_mem_done_end", {63'b0, mem_done}, 64'd0);

    // 6: reset in CMD abandons the transaction; a fresh fetch then completes.
    if_req = 1; if_addr = 64'h9000;
    cyc();
    settle();
    check("t6_bus_req_cmd", {63'b0, bus_req}, 64'd1);
    rst = 1;
    cyc();
    rst = 0;
    settle();
    check("t6_bus_req_rst", {63'b0, bus_req}, 64'd0);
    check("t6_bus_addr_rst", bus_addr, 64'd0);
    cyc();
    serve(64'h9000, 1'b0, 8'h00, 64'h0, 0, 64'h9999);
    check("t6_if_rvalid", {63'b0, if_rvalid}, 64'd1);
    check("t6_if_rdata", if_rdata, 64'h9999);
    cyc();
    bus_rvalid = 0; if_req = 0;
    cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
